// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package bus_arb_pkg;

    typedef enum logic {ST_IDLE, ST_WAIT_RSP} arb_state_e;
    typedef enum logic {MST_IFU, MST_LSU} arb_mst_e;

    // Instruction fetches always read a full word.
    localparam logic [3:0] IFU_SEL = 4'hF;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/response signals between the two masters, the arbiter and the system-bus slave.
interface bus_arbiter_if;

    logic        ifu_req_valid_i;
    logic        ifu_req_ready_o;
    logic [31:0] ifu_addr_i;
    logic        ifu_rsp_valid_o;
    logic        ifu_rsp_ready_i;
    logic [31:0] ifu_rdata_o;

    logic        lsu_req_valid_i;
    logic        lsu_req_ready_o;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_we_i;
    logic [3:0]  lsu_sel_i;
    logic        lsu_rsp_valid_o;
    logic        lsu_rsp_ready_i;
    logic [31:0] lsu_rdata_o;

    logic        bus_req_valid_o;
    logic        bus_req_ready_i;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic        bus_rsp_valid_i;
    logic        bus_rsp_ready_o;
    logic [31:0] bus_rdata_i;

    // slave is the arbiter's own view; master is the surrounding masters plus the bus slave.
    modport slave (
        input  ifu_req_valid_i, ifu_addr_i, ifu_rsp_ready_i,
        input  lsu_req_valid_i, lsu_addr_i, lsu_wdata_i, lsu_we_i, lsu_sel_i, lsu_rsp_ready_i,
        input  bus_req_ready_i, bus_rsp_valid_i, bus_rdata_i,
        output ifu_req_ready_o, ifu_rsp_valid_o, ifu_rdata_o,
        output lsu_req_ready_o, lsu_rsp_valid_o, lsu_rdata_o,
        output bus_req_valid_o, bus_addr_o, bus_wdata_o, bus_we_o, bus_sel_o, bus_rsp_ready_o
    );

    modport master (
        output ifu_req_valid_i, ifu_addr_i, ifu_rsp_ready_i,
        output lsu_req_valid_i, lsu_addr_i, lsu_wdata_i, lsu_we_i, lsu_sel_i, lsu_rsp_ready_i,
        output bus_req_ready_i, bus_rsp_valid_i, bus_rdata_i,
        input  ifu_req_ready_o, ifu_rsp_valid_o, ifu_rdata_o,
        input  lsu_req_ready_o, lsu_rsp_valid_o, lsu_rdata_o,
        input  bus_req_valid_o, bus_addr_o, bus_wdata_o, bus_we_o, bus_sel_o, bus_rsp_ready_o
    );

endinterface

// File: rtl/bus_arb_pick.sv
// Combinational winner selection: a latched grant beats everything, otherwise LSU
// wins unless IFU has been starved for STARVE_LIMIT grants.
module bus_arb_pick
    import bus_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  logic [3:0] starve_cnt,
    input  logic       hold_vld,
    input  arb_mst_e   hold_owner,
    output logic       grant_vld,
    output arb_mst_e   grant_owner
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    always_comb begin
        grant_vld   = 1'b0;
        grant_owner = MST_IFU;
        if (hold_vld) begin
            grant_owner = hold_owner;
            grant_vld   = (hold_owner == MST_LSU) ? lsu_valid : ifu_valid;
        end else if (lsu_valid && (!ifu_valid || (starve_cnt < LIMIT))) begin
            grant_vld   = 1'b1;
            grant_owner = MST_LSU;
        end else if (ifu_valid) begin
            grant_vld   = 1'b1;
            grant_owner = MST_IFU;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (IFU/LSU) to one-slave arbiter, one transaction in flight, with
// LSU priority bounded by a starvation counter.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_arbiter_if.slave       bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e state_q;
    arb_state_e state_d;
    arb_mst_e   owner_q;
    arb_mst_e   hold_owner_q;
    arb_mst_e   grant_owner;
    logic       hold_vld_q;
    logic       grant_vld;
    logic [3:0] starve_cnt_q;
    logic       req_hs;
    logic       rsp_hs;

    bus_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .ifu_valid  (bus.ifu_req_valid_i),
        .lsu_valid  (bus.lsu_req_valid_i),
        .starve_cnt (starve_cnt_q),
        .hold_vld   (hold_vld_q),
        .hold_owner (hold_owner_q),
        .grant_vld  (grant_vld),
        .grant_owner(grant_owner)
    );

    assign req_hs = bus.bus_req_valid_o && bus.bus_req_ready_i;
    assign rsp_hs = (state_q == ST_WAIT_RSP) && bus.bus_rsp_valid_i && bus.bus_rsp_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_IDLE) begin
            if (req_hs) state_d = ST_WAIT_RSP;
        end else begin
            if (rsp_hs) state_d = ST_IDLE;
        end
    end

    // Responses in IDLE are strays: accepted and dropped without reaching either master.
    always_comb begin
        bus.bus_req_valid_o = 1'b0;
        bus.ifu_req_ready_o = 1'b0;
        bus.lsu_req_ready_o = 1'b0;
        bus.ifu_rsp_valid_o = 1'b0;
        bus.lsu_rsp_valid_o = 1'b0;
        bus.bus_rsp_ready_o = 1'b1;
        bus.ifu_rdata_o     = bus.bus_rdata_i;
        bus.lsu_rdata_o     = bus.bus_rdata_i;
        bus.bus_addr_o      = bus.ifu_addr_i;
        bus.bus_wdata_o     = 32'd0;
        bus.bus_we_o        = 1'b0;
        bus.bus_sel_o       = IFU_SEL;
        if (grant_owner == MST_LSU) begin
            bus.bus_addr_o  = bus.lsu_addr_i;
            bus.bus_wdata_o = bus.lsu_wdata_i;
            bus.bus_we_o    = bus.lsu_we_i;
            bus.bus_sel_o   = bus.lsu_sel_i;
        end
        if (state_q == ST_IDLE) begin
            bus.bus_req_valid_o = grant_vld;
            if (grant_owner == MST_LSU) begin
                bus.lsu_req_ready_o = grant_vld && bus.bus_req_ready_i;
            end else begin
                bus.ifu_req_ready_o = grant_vld && bus.bus_req_ready_i;
            end
        end else if (owner_q == MST_LSU) begin
            bus.lsu_rsp_valid_o = bus.bus_rsp_valid_i;
            bus.bus_rsp_ready_o = bus.lsu_rsp_ready_i;
        end else begin
            bus.ifu_rsp_valid_o = bus.bus_rsp_valid_i;
            bus.bus_rsp_ready_o = bus.ifu_rsp_ready_i;
        end
    end

    // A stalled offer is latched so the other master cannot steal the slot mid-request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= MST_IFU;
            hold_vld_q   <= 1'b0;
            hold_owner_q <= MST_IFU;
            starve_cnt_q <= 4'd0;
        end else begin
            if (req_hs) owner_q <= grant_owner;
            if (state_q == ST_IDLE) begin
                hold_vld_q <= bus.bus_req_valid_o && !bus.bus_req_ready_i;
                if (bus.bus_req_valid_o) hold_owner_q <= grant_owner;
            end
            if (!bus.ifu_req_valid_i) begin
                starve_cnt_q <= 4'd0;
            end else if (req_hs) begin
                if (grant_owner == MST_LSU) begin
                    starve_cnt_q <= (starve_cnt_q < LIMIT) ? starve_cnt_q + 4'd1 : LIMIT;
                end else begin
                    starve_cnt_q <= 4'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic,
// all checked each cycle against a transaction-level model of the arbitration rules.
module tb_bus_arbiter;

    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   err_count = 0;
    int   check_count = 0;

    logic [31:0] t_ifu_addr = 32'd0;
    logic [31:0] t_lsu_addr = 32'd0;
    logic [31:0] t_lsu_wdata = 32'd0;
    logic        t_lsu_we = 1'b0;
    logic [3:0]  t_lsu_sel = 4'd0;

    bit m_busy, m_own_lsu, m_lock, m_lock_lsu;
    int m_starve;
    bit acc_ifu, acc_lsu;

    logic        obs_ifu_rdy, obs_lsu_rdy, obs_ifu_rv, obs_lsu_rv, obs_rsp_rdy, obs_we;
    logic [3:0]  obs_sel, obs_starve;
    logic [31:0] obs_addr;

    bit          ifu_pend, lsu_pend, ifu_rv_seen;
    bit          grant_q[$];
    logic [3:0]  cnt_q[$];
    bit          exp_grant[6] = '{1, 1, 1, 1, 0, 1};
    int          exp_cnt[6]   = '{0, 1, 2, 3, 4, 0};

    bus_arbiter_if bif();

    bus_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_busy = 0; m_own_lsu = 0; m_lock = 0; m_lock_lsu = 0; m_starve = 0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        modelReset();
    endtask

    // Drive one cycle of inputs, compare outputs with the model, then advance one clock.
    task automatic applyStimulus(input bit ifu_v, input bit lsu_v, input bit req_rdy,
                                 input bit rsp_v, input bit ifu_rr, input bit lsu_rr);
        logic [31:0] rdata;
        bit win_lsu, offer, done;
        bit e_reqv, e_irdy, e_lrdy, e_irv, e_lrv, e_rsprdy;
        int n_starve;
        rdata = $urandom();
        bif.ifu_req_valid_i = ifu_v;
        bif.ifu_addr_i      = t_ifu_addr;
        bif.ifu_rsp_ready_i = ifu_rr;
        bif.lsu_req_valid_i = lsu_v;
        bif.lsu_addr_i      = t_lsu_addr;
        bif.lsu_wdata_i     = t_lsu_wdata;
        bif.lsu_we_i        = t_lsu_we;
        bif.lsu_sel_i       = t_lsu_sel;
        bif.lsu_rsp_ready_i = lsu_rr;
        bif.bus_req_ready_i = req_rdy;
        bif.bus_rsp_valid_i = rsp_v;
        bif.bus_rdata_i     = rdata;
        #1;
        win_lsu = m_lock ? m_lock_lsu : (lsu_v && (!ifu_v || m_starve < LIM));
        offer = 0; done = 0;
        e_reqv = 0; e_irdy = 0; e_lrdy = 0; e_irv = 0; e_lrv = 0; e_rsprdy = 1;
        if (!m_busy) begin
            offer  = win_lsu ? lsu_v : ifu_v;
            e_reqv = offer;
            e_irdy = offer && !win_lsu && req_rdy;
            e_lrdy = offer && win_lsu && req_rdy;
        end else begin
            e_rsprdy = m_own_lsu ? lsu_rr : ifu_rr;
            e_irv    = !m_own_lsu && rsp_v;
            e_lrv    = m_own_lsu && rsp_v;
            done     = rsp_v && e_rsprdy;
        end
        checkOutput("ctl{reqv,irdy,lrdy,irv,lrv,rsprdy}",
                    {26'd0, bif.bus_req_valid_o, bif.ifu_req_ready_o, bif.lsu_req_ready_o,
                     bif.ifu_rsp_valid_o, bif.lsu_rsp_valid_o, bif.bus_rsp_ready_o},
                    {26'd0, e_reqv, e_irdy, e_lrdy, e_irv, e_lrv, e_rsprdy});
        if (offer) begin
            checkOutput("bus_addr", bif.bus_addr_o, win_lsu ? t_lsu_addr : t_ifu_addr);
            checkOutput("bus_wdata", bif.bus_wdata_o, win_lsu ? t_lsu_wdata : 32'd0);
            checkOutput("bus_we_sel", {27'd0, bif.bus_we_o, bif.bus_sel_o},
                        win_lsu ? {27'd0, t_lsu_we, t_lsu_sel} : {27'd0, 1'b0, 4'hF});
        end
        checkOutput("ifu_rdata", bif.ifu_rdata_o, rdata);
        checkOutput("lsu_rdata", bif.lsu_rdata_o, rdata);
        obs_ifu_rdy = bif.ifu_req_ready_o;
        obs_lsu_rdy = bif.lsu_req_ready_o;
        obs_ifu_rv  = bif.ifu_rsp_valid_o;
        obs_lsu_rv  = bif.lsu_rsp_valid_o;
        obs_rsp_rdy = bif.bus_rsp_ready_o;
        obs_addr    = bif.bus_addr_o;
        obs_we      = bif.bus_we_o;
        obs_sel     = bif.bus_sel_o;
        obs_starve  = dut.starve_cnt_q;
        if (obs_ifu_rv) ifu_rv_seen = 1;
        acc_ifu = offer && !win_lsu && req_rdy;
        acc_lsu = offer && win_lsu && req_rdy;
        n_starve = m_starve;
        if (!ifu_v) n_starve = 0;
        else if (acc_lsu) n_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
        else if (acc_ifu) n_starve = 0;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            modelReset();
        end else begin
            m_starve = n_starve;
            if (!m_busy) begin
                m_lock     = offer && !req_rdy;
                m_lock_lsu = win_lsu;
                if (acc_ifu || acc_lsu) begin
                    m_busy    = 1;
                    m_own_lsu = acc_lsu;
                end
            end else if (done) begin
                m_busy = 0;
            end
        end
    endtask

    initial begin
        modelReset();
        // Reset state
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        checkOutput("reset_starve", {28'd0, dut.starve_cnt_q}, 32'd0);

        // LSU-only write
        t_lsu_addr = 32'h1000_0004; t_lsu_wdata = 32'hCAFE_0001;
        t_lsu_we = 1'b1; t_lsu_sel = 4'b0011;
        ifu_rv_seen = 0;
        applyStimulus(0, 1, 1, 0, 0, 1);
        checkOutput("lsu_only_we_sel", {27'd0, obs_we, obs_sel}, {27'd0, 1'b1, 4'b0011});
        checkOutput("lsu_only_req_ready", {31'd0, obs_lsu_rdy}, 32'd1);
        applyStimulus(0, 0, 0, 1, 0, 1);
        checkOutput("lsu_only_rsp_valid", {31'd0, obs_lsu_rv}, 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("lsu_only_ifu_rsp_never", {31'd0, ifu_rv_seen}, 32'd0);

        // Starvation: both masters valid continuously
        t_ifu_addr = 32'h0000_0100; t_lsu_we = 1'b0; t_lsu_sel = 4'hF;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1, 1, 1, 1, 1, 1);
            if (obs_lsu_rdy || obs_ifu_rdy) begin
                grant_q.push_back(obs_lsu_rdy);
                cnt_q.push_back(obs_starve);
            end
        end
        checkOutput("starve_grant_count", {31'd0, grant_q.size() >= 6}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_q.size()) begin
                checkOutput($sformatf("starve_grant_is_lsu[%0d]", i), {31'd0, grant_q[i]}, {31'd0, exp_grant[i]});
                checkOutput($sformatf("starve_cnt[%0d]", i), {28'd0, cnt_q[i]}, exp_cnt[i]);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Grant lock: IFU offered alone, LSU arrives while slave is stalled
        t_ifu_addr = 32'h0000_2000; t_lsu_addr = 32'h1000_0040;
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("lock_addr_c0", obs_addr, 32'h0000_2000);
        for (int i = 1; i < 3; i++) begin
            applyStimulus(1, 1, 0, 0, 0, 0);
            checkOutput($sformatf("lock_addr_c%0d", i), obs_addr, 32'h0000_2000);
        end
        applyStimulus(1, 1, 1, 0, 0, 0);
        checkOutput("lock_handshake_ifu", {30'd0, obs_ifu_rdy, obs_lsu_rdy}, 32'd2);
        applyStimulus(0, 1, 0, 1, 1, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        checkOutput("lsu_after_lock", {31'd0, obs_lsu_rdy}, 32'd1);

        // Response backpressure with the LSU owning the bus
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 1, 1, 1, 0);
            checkOutput("bp_rsp_ready", {31'd0, obs_rsp_rdy}, 32'd0);
            checkOutput("bp_no_accept", {31'd0, obs_ifu_rdy}, 32'd0);
        end
        applyStimulus(1, 0, 1, 1, 1, 1);
        checkOutput("rsp_cycle_no_accept", {31'd0, obs_ifu_rdy}, 32'd0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("next_cycle_accept", {31'd0, obs_ifu_rdy}, 32'd1);
        applyStimulus(0, 0, 0, 1, 1, 1);

        // Reset while waiting for a response, then a late (stray) response
        applyStimulus(0, 1, 1, 0, 0, 0);
        doReset();
        applyStimulus(0, 0, 0, 1, 1, 1);
        checkOutput("stray_rsp_ready", {31'd0, obs_rsp_rdy}, 32'd1);
        checkOutput("stray_rsp_valids", {30'd0, obs_ifu_rv, obs_lsu_rv}, 32'd0);
        applyStimulus(0, 1, 1, 1, 1, 1);
        checkOutput("idle_after_stray", {31'd0, obs_lsu_rdy}, 32'd1);
        applyStimulus(0, 0, 0, 1, 1, 1);

        // Random traffic; masters hold their request until it is accepted
        ifu_pend = 0; lsu_pend = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!ifu_pend && $urandom_range(2) == 0) begin
                ifu_pend = 1;
                t_ifu_addr = $urandom();
            end
            if (!lsu_pend && $urandom_range(2) == 0) begin
                lsu_pend = 1;
                t_lsu_addr  = $urandom();
                t_lsu_wdata = $urandom();
                t_lsu_we    = 1'($urandom_range(1));
                t_lsu_sel   = 4'($urandom_range(15));
            end
            if ($urandom_range(299) == 0) doReset();
            applyStimulus(ifu_pend, lsu_pend, $urandom_range(3) != 0, $urandom_range(1) == 1,
                          $urandom_range(3) != 0, $urandom_range(3) != 0);
            if (acc_ifu) ifu_pend = 0;
            if (acc_lsu) lsu_pend = 0;
        end

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
